// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared async-FIFO pointer width, depth and Gray conversion helpers
package fifo_pkg;

    localparam int ADDR_W_DEFAULT = 5;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

    localparam int DEPTH_DEFAULT = depth_of(ADDR_W_DEFAULT);

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR by doubling shifts: bit i ends up as the XOR of all bits >= i.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        b = b ^ (b >> 1);
        b = b ^ (b >> 2);
        b = b ^ (b >> 4);
        b = b ^ (b >> 8);
        b = b ^ (b >> 16);
        return b;
    endfunction

endpackage

// File: rtl/gray2bin_n.sv
// rtl/gray2bin_n.sv - parametrised Gray-to-binary converter, MSB-first XOR chain
module gray2bin_n #(
    parameter int W = 6
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    logic acc;

    always_comb begin
        acc = 1'b0;
        bin = '0;
        for (int i = W - 1; i >= 0; i--) begin
            acc    = acc ^ gray[i];
            bin[i] = acc;
        end
    end

endmodule

// File: rtl/rptr_ctrl.sv
// rtl/rptr_ctrl.sv - async FIFO read-side pointer, empty/level and underflow tracking
module rptr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEFAULT,
    parameter int AE_DEFAULT = 2
) (
    input  logic              rclk,
    input  logic              rrst,
    input  logic              ren,
    input  logic [ADDR_W:0]   wptr_sync,
    input  logic [ADDR_W:0]   ae_thresh,
    input  logic              ae_use_default,
    input  logic              clr_err,
    output logic [ADDR_W-1:0] raddr,
    output logic [ADDR_W:0]   rptr,
    output logic              empty,
    output logic              almost_empty,
    output logic [ADDR_W:0]   rlevel,
    output logic              rvalid,
    output logic              underflow
);

    localparam logic [ADDR_W:0] DEPTH_P  = (ADDR_W + 1)'(depth_of(ADDR_W));
    localparam logic [ADDR_W:0] AE_DEF_P = (ADDR_W + 1)'(AE_DEFAULT);

    logic [ADDR_W:0] rbin;
    logic [ADDR_W:0] rbin_nxt;
    logic [ADDR_W:0] rptr_nxt;
    logic [ADDR_W:0] wbin;
    logic [ADDR_W:0] diff;
    logic [ADDR_W:0] level_nxt;
    logic [ADDR_W:0] thr;
    logic            pop;

    gray2bin_n #(.W(ADDR_W + 1)) u_wptr_g2b (
        .gray (wptr_sync),
        .bin  (wbin)
    );

    // Only the registered empty gates the pop, so ren never reaches an output combinationally.
    assign pop      = ren & ~empty;
    assign rbin_nxt = rbin + {{ADDR_W{1'b0}}, pop};
    assign rptr_nxt = rbin_nxt ^ (rbin_nxt >> 1);

    // Comparing against rbin_nxt keeps a same-cycle pop from being counted as still present.
    assign diff      = wbin - rbin_nxt;
    assign level_nxt = (diff > DEPTH_P) ? DEPTH_P : diff;
    assign thr       = ae_use_default ? AE_DEF_P : ae_thresh;

    assign raddr = rbin[ADDR_W-1:0];

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rbin         <= '0;
            rptr         <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            rlevel       <= '0;
            rvalid       <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            rbin         <= rbin_nxt;
            rptr         <= rptr_nxt;
            empty        <= (rptr_nxt == wptr_sync);
            almost_empty <= (level_nxt <= thr);
            rlevel       <= level_nxt;
            rvalid       <= pop;
            if (ren && empty)
                underflow <= 1'b1;
            else if (clr_err)
                underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rptr_ctrl.sv
// tb/tb_rptr_ctrl.sv - self-checking bench for rptr_ctrl against a count-based FIFO model
module tb_rptr_ctrl;

    logic       rclk;
    logic       rrst;
    logic       ren;
    logic [5:0] wptr_sync;
    logic [5:0] ae_thresh;
    logic       ae_use_default;
    logic       clr_err;
    logic [4:0] raddr;
    logic [5:0] rptr;
    logic       empty;
    logic       almost_empty;
    logic [5:0] rlevel;
    logic       rvalid;
    logic       underflow;

    int total = 0;
    int bad   = 0;

    // Model: total entries ever read and written, as plain integers.
    int   m_rd, m_wr, m_level;
    logic m_empty, m_ae, m_rvalid, m_uf;

    rptr_ctrl #(.ADDR_W(5), .AE_DEFAULT(2)) dut (
        .rclk           (rclk),
        .rrst           (rrst),
        .ren            (ren),
        .wptr_sync      (wptr_sync),
        .ae_thresh      (ae_thresh),
        .ae_use_default (ae_use_default),
        .clr_err        (clr_err),
        .raddr          (raddr),
        .rptr           (rptr),
        .empty          (empty),
        .almost_empty   (almost_empty),
        .rlevel         (rlevel),
        .rvalid         (rvalid),
        .underflow      (underflow)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    function automatic logic [5:0] gray_of(input int v);
        logic [5:0] b;
        b = 6'(v % 64);
        return b ^ (b >> 1);
    endfunction

    task automatic model_reset();
        m_rd = 0; m_wr = 0; m_level = 0;
        m_empty = 1'b1; m_ae = 1'b1; m_rvalid = 1'b0; m_uf = 1'b0;
    endtask

    task automatic model_edge(input logic r, input logic c);
        int d, thr;
        logic p;
        p = r && !m_empty;
        if (r && m_empty) m_uf = 1'b1;
        else if (c)       m_uf = 1'b0;
        if (p) m_rd++;
        m_rvalid = p;
        d = (((m_wr - m_rd) % 64) + 64) % 64;
        m_level = (d > 32) ? 32 : d;
        m_empty = (d == 0);
        thr = ae_use_default ? 2 : int'(ae_thresh);
        m_ae = (m_level <= thr);
    endtask

    task automatic cycle(input logic r, input logic c);
        @(negedge rclk);
        ren = r; clr_err = c; wptr_sync = gray_of(m_wr);
        @(posedge rclk);
        model_edge(r, c);
        #1;
    endtask

    task automatic test_reset();
        rrst = 1'b1; ren = 1'b0; clr_err = 1'b0; wptr_sync = '0;
        ae_thresh = '0; ae_use_default = 1'b1;
        model_reset();
        repeat (2) @(posedge rclk);
        #1;
        total++; if (empty !== 1'b1)        begin bad++; $display("FAIL reset_empty got=%0d exp=1", empty); end
        total++; if (almost_empty !== 1'b1) begin bad++; $display("FAIL reset_ae got=%0d exp=1", almost_empty); end
        total++; if (rlevel !== 6'd0)       begin bad++; $display("FAIL reset_level got=%0d exp=0", rlevel); end
        total++; if (rptr !== 6'd0)         begin bad++; $display("FAIL reset_rptr got=%0h exp=0", rptr); end
        total++; if (underflow !== 1'b0)    begin bad++; $display("FAIL reset_uf got=%0d exp=0", underflow); end
        total++; if (rvalid !== 1'b0)       begin bad++; $display("FAIL reset_rvalid got=%0d exp=0", rvalid); end
        @(negedge rclk);
        rrst = 1'b0;
    endtask

    task automatic test_fill();
        m_wr = 5;
        cycle(1'b0, 1'b0);
        total++; if (empty !== 1'b0)        begin bad++; $display("FAIL fill_empty got=%0d exp=0", empty); end
        total++; if (rlevel !== 6'd5)       begin bad++; $display("FAIL fill_level got=%0d exp=5", rlevel); end
        total++; if (almost_empty !== 1'b0) begin bad++; $display("FAIL fill_ae got=%0d exp=0", almost_empty); end
        total++; if (raddr !== 5'd0)        begin bad++; $display("FAIL fill_raddr got=%0d exp=0", raddr); end
    endtask

    task automatic test_pop();
        for (int k = 1; k <= 3; k++) begin
            cycle(1'b1, 1'b0);
            total++; if (rvalid !== 1'b1)   begin bad++; $display("FAIL pop_rvalid k=%0d got=%0d exp=1", k, rvalid); end
            total++; if (raddr !== 5'(k))   begin bad++; $display("FAIL pop_raddr got=%0d exp=%0d", raddr, k); end
            total++; if (rlevel !== 6'(5-k)) begin bad++; $display("FAIL pop_level got=%0d exp=%0d", rlevel, 5 - k); end
        end
        cycle(1'b0, 1'b0);
        total++; if (rvalid !== 1'b0)       begin bad++; $display("FAIL pop_rvalid_idle got=%0d exp=0", rvalid); end
        total++; if (rlevel !== 6'd2)       begin bad++; $display("FAIL pop_level2 got=%0d exp=2", rlevel); end
        total++; if (almost_empty !== 1'b1) begin bad++; $display("FAIL pop_ae got=%0d exp=1", almost_empty); end
        cycle(1'b1, 1'b0);
        total++; if (empty !== 1'b0)        begin bad++; $display("FAIL pop4_empty got=%0d exp=0", empty); end
        cycle(1'b1, 1'b0);
        total++; if (empty !== 1'b1)        begin bad++; $display("FAIL pop5_empty got=%0d exp=1", empty); end
        total++; if (rlevel !== 6'd0)       begin bad++; $display("FAIL pop5_level got=%0d exp=0", rlevel); end
    endtask

    task automatic test_underflow();
        cycle(1'b1, 1'b0);
        total++; if (rptr !== gray_of(5))   begin bad++; $display("FAIL uf_rptr got=%0h exp=%0h", rptr, gray_of(5)); end
        total++; if (rvalid !== 1'b0)       begin bad++; $display("FAIL uf_rvalid got=%0d exp=0", rvalid); end
        total++; if (underflow !== 1'b1)    begin bad++; $display("FAIL uf_set got=%0d exp=1", underflow); end
        cycle(1'b1, 1'b1);
        total++; if (underflow !== 1'b1)    begin bad++; $display("FAIL uf_set_wins got=%0d exp=1", underflow); end
        cycle(1'b0, 1'b1);
        total++; if (underflow !== 1'b0)    begin bad++; $display("FAIL uf_clear got=%0d exp=0", underflow); end
    endtask

    task automatic test_random_to_60();
        int n;
        n = 0;
        while (m_rd < 60 && n < 3000) begin
            if (m_wr < 60 && (m_wr - m_rd) < 32 && $urandom_range(0, 1) == 1) m_wr++;
            ae_thresh      = 6'($urandom_range(0, 8));
            ae_use_default = ($urandom_range(0, 3) == 0);
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
            n++;
            total++; if (raddr !== 5'(m_rd % 32))   begin bad++; $display("FAIL rnd_raddr got=%0d exp=%0d", raddr, m_rd % 32); end
            total++; if (rptr !== gray_of(m_rd))    begin bad++; $display("FAIL rnd_rptr got=%0h exp=%0h", rptr, gray_of(m_rd)); end
            total++; if (empty !== m_empty)         begin bad++; $display("FAIL rnd_empty got=%0d exp=%0d", empty, m_empty); end
            total++; if (rlevel !== 6'(m_level))    begin bad++; $display("FAIL rnd_level got=%0d exp=%0d", rlevel, m_level); end
            total++; if (almost_empty !== m_ae)     begin bad++; $display("FAIL rnd_ae got=%0d exp=%0d", almost_empty, m_ae); end
            total++; if (rvalid !== m_rvalid)       begin bad++; $display("FAIL rnd_rvalid got=%0d exp=%0d", rvalid, m_rvalid); end
            total++; if (underflow !== m_uf)        begin bad++; $display("FAIL rnd_uf got=%0d exp=%0d", underflow, m_uf); end
        end
        total++; if (m_rd != 60) begin bad++; $display("FAIL rnd_budget got=%0d exp=60", m_rd); end
        ae_use_default = 1'b1;
        ae_thresh      = '0;
        cycle(1'b0, 1'b1);
    endtask

    task automatic test_wrap();
        logic [5:0] prev;
        m_wr = 92;
        cycle(1'b0, 1'b0);
        total++; if (rlevel !== 6'd32)      begin bad++; $display("FAIL wrap_level got=%0d exp=32", rlevel); end
        total++; if (empty !== 1'b0)        begin bad++; $display("FAIL wrap_empty got=%0d exp=0", empty); end
        for (int k = 0; k < 32; k++) begin
            prev = rptr;
            cycle(1'b1, 1'b0);
            total++; if ($countones(rptr ^ prev) != 1) begin bad++; $display("FAIL wrap_gray_step got=%0h prev=%0h exp=one_bit", rptr, prev); end
            total++; if (rptr !== gray_of(m_rd))      begin bad++; $display("FAIL wrap_rptr got=%0h exp=%0h", rptr, gray_of(m_rd)); end
            total++; if (empty !== (k == 31))         begin bad++; $display("FAIL wrap_empty k=%0d got=%0d exp=%0d", k, empty, k == 31); end
            total++; if (rlevel !== 6'(31 - k))       begin bad++; $display("FAIL wrap_level got=%0d exp=%0d", rlevel, 31 - k); end
        end
        total++; if (raddr !== 5'd28)       begin bad++; $display("FAIL wrap_raddr got=%0d exp=28", raddr); end
    endtask

    task automatic test_reset_mid();
        m_wr = m_rd + 10;
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        @(negedge rclk);
        ren = 1'b1;
        #1 rrst = 1'b1;
        #1;
        total++; if (rptr !== 6'd0 || raddr !== 5'd0) begin bad++; $display("FAIL rstmid_ptr got=%0h/%0h exp=0", rptr, raddr); end
        total++; if (empty !== 1'b1 || almost_empty !== 1'b1) begin bad++; $display("FAIL rstmid_empty got=%0d/%0d exp=1", empty, almost_empty); end
        total++; if (rlevel !== 6'd0 || rvalid !== 1'b0 || underflow !== 1'b0) begin bad++; $display("FAIL rstmid_misc got=%0d/%0d/%0d exp=0", rlevel, rvalid, underflow); end
        @(posedge rclk);
        #1;
        total++; if (rptr !== 6'd0 || empty !== 1'b1 || rvalid !== 1'b0) begin bad++; $display("FAIL rstmid_hold got=%0h/%0d/%0d exp=0/1/0", rptr, empty, rvalid); end
        @(negedge rclk);
        model_reset();
        ren = 1'b0; wptr_sync = '0; rrst = 1'b0;
        cycle(1'b0, 1'b0);
        total++; if (rptr !== 6'd0 || empty !== 1'b1) begin bad++; $display("FAIL rstmid_release got=%0h/%0d exp=0/1", rptr, empty); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_pop();
        test_underflow();
        test_random_to_60();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
